lsu_mem: RTL and testbench
==========================

# lsu_mem

Parametrised, multi-cycle, byte-addressed data memory with a load/store front end for the nano-cpu core. It accepts one RV32 load or store request at a time over a valid/ready handshake. It performs byte, halfword and word accesses in little-endian order, with sign or zero extension on loads, and returns a single-cycle response after a configurable access latency. Misaligned, out-of-range and illegal-width accesses are reported as faults instead of touching memory. It replaces the inline word-only memory access in the processor datapath.

## Interface
- `ADDR_WIDTH`, 16: memory size is 2^ADDR_WIDTH bytes; legal range 8..20.
- `LATENCY`, 1: number of BUSY cycles between request acceptance and the response; legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block is idle and will accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 selecting access width and extension.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low bytes are used for SB and SH.
- `resp_valid` out 1: response pulse, one cycle.
- `resp_rdata` out 32: load result; 0 for stores and for faults.
- `resp_fault` out 1: request was rejected (misaligned, out of range, or illegal funct3).

## Operation
- Storage is `reg [7:0]` × 2^ADDR_WIDTH. Memory is not cleared by reset.
- Verilator-only public backdoor tasks `read_memory_byte` and `write_memory_byte` use address bits `[ADDR_WIDTH-1:0]`.
- **Byte order:** little-endian. Byte at `addr` maps to data bits `[7:0]`; byte at `addr+3` maps to bits `[31:24]`.
- **Loads, by funct3:**
  - 0 = LB: sign-extend.
  - 1 = LH: sign-extend.
  - 2 = LW.
  - 4 = LBU: zero-extend.
  - 5 = LHU: zero-extend.
  - 3, 6, 7 are illegal.
- **Stores, by funct3:**
  - 0 = SB: writes `wdata[7:0]`.
  - 1 = SH: writes `wdata[15:0]`.
  - 2 = SW: writes all 32 bits.
  - 3..7 are illegal.
- **Fault conditions:** any of the following sets the fault.
  - Illegal funct3.
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Any of `addr[31:ADDR_WIDTH]` nonzero.
- **Fault handling:** a faulting request takes the same latency, writes nothing, and returns `resp_rdata` = 0 with `resp_fault` = 1.
- **Request capture:** `req_we`, `req_funct3`, `req_addr` and `req_wdata` are registered at acceptance. Later input changes have no effect on the in-flight request.
- **State machine:**
  - IDLE: `req_ready` = 1. On `req_valid`, capture the request, load the counter with LATENCY-1, and go to BUSY.
  - BUSY: `req_ready` = 0. If the counter ≠ 0, decrement it. If the counter = 0, then on that edge:
    - perform the store write (if store and not faulted);
    - register the load data, extension and fault into the response registers;
    - go to RESP.
  - RESP: `resp_valid` = 1, `req_ready` = 0. The next edge returns to IDLE.
- There is no response backpressure. The consumer must take the response in the RESP cycle.
- `req_valid` is ignored outside IDLE.

## Timing
- **Response latency:** a request accepted at edge N has `resp_valid` high in the cycle following edge N+LATENCY, for exactly one cycle. `req_ready` is high again after edge N+LATENCY+1.
- **Throughput:** maximum one request per LATENCY+2 cycles.
- **Write visibility:** a store's memory write occurs at edge N+LATENCY. A load accepted afterwards observes it.
- **Reset values:** while `rst` is high, and immediately after deassertion:
  - state = IDLE, counter = 0;
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_fault` = 0;
  - `req_ready` is forced to 0 while `rst` is asserted and is 1 in the first cycle after release.
- **Reset mid-operation:** asserting `rst` in BUSY aborts the request; a pending store is not written. Asserting it in RESP drops the response pulse.
- **Response register hold:** `resp_rdata` and `resp_fault` hold their values until the next response is registered. They are meaningful only while `resp_valid` = 1.

## Test plan
- **Word store and byte/word loads** (LATENCY = 1): SW 0x11223344 @0x100, then
  - LW @0x100 → 0x11223344;
  - LBU @0x100 → 0x00000044;
  - LB @0x103 → 0x00000011;
  - the SW response has rdata 0 and fault 0.
- **Byte and halfword sign/zero extension:** SB wdata 0xABCDEF80 @0x201, SB 0x7F @0x200, then
  - LB @0x201 → 0xFFFFFF80;
  - LBU @0x201 → 0x00000080;
  - LH @0x200 → 0xFFFF807F;
  - LHU @0x200 → 0x0000807F.
- **Misalignment faults:** backdoor-write 0xAA to 0x101, then
  - LW @0x102 → fault 1, rdata 0;
  - SH 0x5555 @0x101 → fault 1, and byte 0x101 still reads 0xAA;
  - LH @0x102 → fault 0.
- **Range and funct3 faults** (ADDR_WIDTH = 16):
  - LW @0x00010000 → fault 1;
  - a load with funct3 = 3 → fault 1;
  - a store with funct3 = 4 → fault 1 and memory unchanged.
- **Latency and handshake** (LATENCY = 3):
  - a request accepted at edge N gives `resp_valid` after edge N+3, for exactly one cycle;
  - `req_ready` is 0 for 4 cycles;
  - `req_valid` held high during BUSY with a different address is not accepted;
  - a second request is accepted on the first ready cycle.
- **Reset mid-operation:** issue SW 0xDEADBEEF @0x40 (LATENCY = 3) and pulse `rst` during BUSY.
  - `resp_valid` never rises.
  - After release, `req_ready` = 1 and LW @0x40 returns its prior content.

Source files
------------

// File: rtl/lsu_mem.sv
// Byte-addressed data memory behind a single-request load/store front end.
// Handles RV32 byte/half/word accesses (little-endian) and reports misaligned,
// out-of-range or illegal-width requests as faults after the normal latency.
module lsu_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;

    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [7:0]  mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx0;
    logic [ADDR_WIDTH-1:0] idx1;
    logic [ADDR_WIDTH-1:0] idx2;
    logic [ADDR_WIDTH-1:0] idx3;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic        do_access;
    logic [31:0] raw;
    logic [31:0] load_val;

    assign idx0 = cap_addr[ADDR_WIDTH-1:0];
    assign idx1 = idx0 + ADDR_WIDTH'(1);
    assign idx2 = idx0 + ADDR_WIDTH'(2);
    assign idx3 = idx0 + ADDR_WIDTH'(3);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE and never in reset.
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign do_access  = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        is_byte      = (cap_funct3[1:0] == 2'b00);
        is_half      = (cap_funct3[1:0] == 2'b01);
        is_word      = (cap_funct3[1:0] == 2'b10);
        illegal      = cap_we ? (cap_funct3 > 3'd2)
                              : ((cap_funct3 == 3'd3) || (cap_funct3[2:1] == 2'b11));
        misaligned   = (is_half && cap_addr[0]) || (is_word && (cap_addr[1:0] != 2'b00));
        out_of_range = (cap_addr >> ADDR_WIDTH) != 32'd0;
        fault        = illegal || misaligned || out_of_range;
    end

    // Neighbouring bytes wrap within the array; only bytes covered by a legal
    // access ever reach the result.
    always_comb begin
        raw = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
        case (cap_funct3)
            3'd0:    load_val = {{24{raw[7]}}, raw[7:0]};
            3'd1:    load_val = {{16{raw[15]}}, raw[15:0]};
            3'd2:    load_val = raw;
            3'd4:    load_val = {24'd0, raw[7:0]};
            3'd5:    load_val = {16'd0, raw[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = BUSY;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_we     <= req_we;
                cap_funct3 <= req_funct3;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
            end
            if (do_access) begin
                resp_rdata <= (cap_we || fault) ? 32'd0 : load_val;
                resp_fault <= fault;
            end
        end
    end

    // Storage is deliberately left out of reset; a reset during BUSY moves the
    // state to IDLE before any edge can reach do_access.
    always_ff @(posedge clk) begin
        if (do_access && cap_we && !fault) begin
            mem[idx0] <= cap_wdata[7:0];
            if (!is_byte) begin
                mem[idx1] <= cap_wdata[15:8];
            end
            if (is_word) begin
                mem[idx2] <= cap_wdata[23:16];
                mem[idx3] <= cap_wdata[31:24];
            end
        end
    end

    task automatic read_memory_byte(input logic [31:0] addr, output logic [7:0] data);
        data = mem[addr[ADDR_WIDTH-1:0]];
    endtask

    task write_memory_byte(input logic [31:0] addr, input logic [7:0] data);
        mem[addr[ADDR_WIDTH-1:0]] <= data;
    endtask

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: one LATENCY=1 and one LATENCY=3 instance,
// hand-computed expectations checked with immediate assertions.
module tb_lsu_mem;

    logic        clk;
    logic        rst;

    logic        req_valid1, req_we1, req_ready1, resp_valid1, resp_fault1;
    logic [2:0]  req_funct3_1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;

    logic        req_valid3, req_we3, req_ready3, resp_valid3, resp_fault3;
    logic [2:0]  req_funct3_3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_mem #(.ADDR_WIDTH(16), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_funct3(req_funct3_1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_fault(resp_fault1)
    );

    lsu_mem #(.ADDR_WIDTH(16), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
        .req_funct3(req_funct3_3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_fault(resp_fault3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s3, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s3) begin
            req_valid3 = v; req_we3 = we; req_funct3_3 = f3; req_addr3 = a; req_wdata3 = wd;
        end else begin
            req_valid1 = v; req_we1 = we; req_funct3_1 = f3; req_addr1 = a; req_wdata1 = wd;
        end
    endtask

    function automatic logic ready_of(input bit s3);
        return s3 ? req_ready3 : req_ready1;
    endfunction

    function automatic logic rvalid_of(input bit s3);
        return s3 ? resp_valid3 : resp_valid1;
    endfunction

    // One complete transaction; bounded waits so a stuck DUT still reaches the summary.
    task automatic xact(input bit s3, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic fl);
        int t;
        logic got;
        @(negedge clk);
        t = 0;
        while (!ready_of(s3) && t < 50) begin
            @(negedge clk);
            t++;
        end
        drive(s3, 1'b1, we, f3, a, wd);
        @(posedge clk);
        #1 drive(s3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        got = 1'b0;
        rd  = 32'd0;
        fl  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rvalid_of(s3)) begin
                got = 1'b1;
                rd  = s3 ? resp_rdata3 : resp_rdata1;
                fl  = s3 ? resp_fault3 : resp_fault1;
            end
        end
        if (!got) check("resp_timeout", {31'd0, got}, 32'd1);
    endtask

    logic [31:0] rd, r_first, r_second;
    logic        fl, seen;
    logic [7:0]  b;
    logic [9:0]  ready_seen, valid_seen;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("ready_in_reset", {31'd0, req_ready1}, 32'd0);
        check("resp_valid_in_reset", {31'd0, resp_valid1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, req_ready1}, 32'd1);
        check("rdata_after_reset", resp_rdata1, 32'd0);
        check("fault_after_reset", {31'd0, resp_fault1}, 32'd0);

        // Word store and byte/word loads
        xact(1'b0, 1'b1, 3'd2, 32'h100, 32'h11223344, rd, fl);
        check("sw_rdata", rd, 32'd0);
        check("sw_fault", {31'd0, fl}, 32'd0);
        xact(1'b0, 1'b0, 3'd2, 32'h100, 32'd0, rd, fl);
        check("lw_100", rd, 32'h11223344);
        xact(1'b0, 1'b0, 3'd4, 32'h100, 32'd0, rd, fl);
        check("lbu_100", rd, 32'h00000044);
        xact(1'b0, 1'b0, 3'd0, 32'h103, 32'd0, rd, fl);
        check("lb_103", rd, 32'h00000011);

        // Sign and zero extension
        xact(1'b0, 1'b1, 3'd0, 32'h201, 32'hABCDEF80, rd, fl);
        xact(1'b0, 1'b1, 3'd0, 32'h200, 32'h0000007F, rd, fl);
        xact(1'b0, 1'b0, 3'd0, 32'h201, 32'd0, rd, fl);
        check("lb_201", rd, 32'hFFFFFF80);
        xact(1'b0, 1'b0, 3'd4, 32'h201, 32'd0, rd, fl);
        check("lbu_201", rd, 32'h00000080);
        xact(1'b0, 1'b0, 3'd1, 32'h200, 32'd0, rd, fl);
        check("lh_200", rd, 32'hFFFF807F);
        xact(1'b0, 1'b0, 3'd5, 32'h200, 32'd0, rd, fl);
        check("lhu_200", rd, 32'h0000807F);

        // Misalignment faults; memory now holds 0x1122AA44 at 0x100
        xact(1'b0, 1'b1, 3'd0, 32'h101, 32'h000000AA, rd, fl);
        xact(1'b0, 1'b0, 3'd2, 32'h102, 32'd0, rd, fl);
        check("lw_102_fault", {31'd0, fl}, 32'd1);
        check("lw_102_rdata", rd, 32'd0);
        xact(1'b0, 1'b1, 3'd1, 32'h101, 32'h00005555, rd, fl);
        check("sh_101_fault", {31'd0, fl}, 32'd1);
        u1.read_memory_byte(32'h101, b);
        check("byte_101_kept", {24'd0, b}, 32'h000000AA);
        xact(1'b0, 1'b0, 3'd1, 32'h102, 32'd0, rd, fl);
        check("lh_102_fault", {31'd0, fl}, 32'd0);
        check("lh_102_rdata", rd, 32'h00001122);

        // Range and funct3 faults
        xact(1'b0, 1'b0, 3'd2, 32'h00010000, 32'd0, rd, fl);
        check("lw_range_fault", {31'd0, fl}, 32'd1);
        xact(1'b0, 1'b0, 3'd3, 32'h100, 32'd0, rd, fl);
        check("ld_f3_3_fault", {31'd0, fl}, 32'd1);
        check("ld_f3_3_rdata", rd, 32'd0);
        xact(1'b0, 1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, rd, fl);
        check("st_f3_4_fault", {31'd0, fl}, 32'd1);
        xact(1'b0, 1'b0, 3'd2, 32'h100, 32'd0, rd, fl);
        check("mem_unchanged", rd, 32'h1122AA44);

        // Latency and handshake on the LATENCY=3 instance
        xact(1'b1, 1'b1, 3'd2, 32'h100, 32'hCAFEF00D, rd, fl);
        xact(1'b1, 1'b1, 3'd2, 32'h104, 32'h0BADC0DE, rd, fl);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        @(posedge clk);
        #1 req_addr3 = 32'h104;
        ready_seen = '0;
        valid_seen = '0;
        r_first    = '0;
        r_second   = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            ready_seen[i-1] = req_ready3;
            valid_seen[i-1] = resp_valid3;
            if (i == 4) r_first = resp_rdata3;
            if (i == 9) r_second = resp_rdata3;
            if (i == 5) begin
                @(posedge clk);
                #1 req_valid3 = 1'b0;
            end
        end
        check("ready_pattern", {22'd0, ready_seen}, 32'h00000210);
        check("resp_valid_pattern", {22'd0, valid_seen}, 32'h00000108);
        check("first_resp_data", r_first, 32'hCAFEF00D);
        check("second_resp_data", r_second, 32'h0BADC0DE);

        // Reset mid-operation aborts a pending store
        xact(1'b1, 1'b1, 3'd2, 32'h40, 32'h12345678, rd, fl);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        #1;
        check("ready_forced_low", {31'd0, req_ready3}, 32'd0);
        seen = resp_valid3;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid3;
        end
        rst = 1'b0;
        #1;
        check("ready_after_abort", {31'd0, req_ready3}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            seen = seen | resp_valid3;
        end
        check("no_resp_after_abort", {31'd0, seen}, 32'd0);
        xact(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, rd, fl);
        check("lw_40_prior", rd, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
